// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial adder: state encoding,
// slice width and the nibble-index width helper.
package adder_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Width of the nibble index for a given operand width; a single-nibble
    // datapath still needs one bit to hold the index register.
    function automatic int idx_w(input int width);
        return (width / NIB_W > 1) ? $clog2(width / NIB_W) : 1;
    endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Operand/result handshake bundle for the nibble-serial adder.
// The master drives operands and consumes results; the slave is the adder.
interface nibble_serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/nibble_serial_adder_cla4_slice.sv
// Combinational 4-bit carry-lookahead slice. c3 is the carry into bit 3,
// exported so the caller can form signed overflow as c3 ^ co.
module cla4_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co,
    output logic       c3
);
    logic [3:0] g;
    logic [3:0] p;
    logic       c1;
    logic       c2;

    assign g = a & b;
    assign p = a ^ b;

    // Flat lookahead: every carry is a two-level function of g, p and ci.
    assign c1 = g[0] | (p[0] & ci);
    assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & ci);
    assign co = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & ci);

    assign s = p ^ {c3, c2, c1, ci};
endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that walks one nibble per clock through a shared 4-bit CLA
// slice, LSB nibble first, with the carry held in a register between nibbles.
module nibble_serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    nibble_serial_adder_if.slave bus
);
    localparam int NIB   = WIDTH / NIB_W;
    localparam int IDX_W = idx_w(WIDTH);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NIB - 1);

    state_e             state;
    logic [IDX_W-1:0]   idx;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   sum_q;
    logic               carry;
    logic               cout_q;
    logic               ovf_q;

    logic [NIB_W-1:0]   a_nib;
    logic [NIB_W-1:0]   b_nib;
    logic [NIB_W-1:0]   s_nib;
    logic               co;
    logic               c3;

    assign a_nib = a_q[int'(idx)*NIB_W +: NIB_W];
    assign b_nib = b_q[int'(idx)*NIB_W +: NIB_W];

    cla4_slice u_slice (
        .a  (a_nib),
        .b  (b_nib),
        .ci (carry),
        .s  (s_nib),
        .co (co),
        .c3 (c3)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            idx    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            sum_q  <= '0;
            carry  <= 1'b0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q   <= bus.a;
                        b_q   <= bus.b;
                        carry <= bus.cin;
                        idx   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sum_q[int'(idx)*NIB_W +: NIB_W] <= s_nib;
                    carry <= co;
                    // Final nibble: its carries define the unsigned and signed flags.
                    if (idx == LAST) begin
                        cout_q <= co;
                        ovf_q  <= c3 ^ co;
                        idx    <= '0;
                        state  <= DONE;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake outputs decode registered state only, so no input reaches them.
    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Randomised bench for nibble_serial_adder against an integer-arithmetic model.
module tb_nibble_serial_adder;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    nibble_serial_adder_if #(.WIDTH(W)) bus ();

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {ovf, cout, sum} from plain unsigned and signed integer addition.
    function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y, input logic c);
        int unsigned u;
        int          s;
        logic        o;
        u = int'(x) + int'(y) + int'(c);
        s = int'($signed(x)) + int'($signed(y)) + int'(c);
        o = (s > 32767) || (s < -32768);
        return {o, u[16], u[15:0]};
    endfunction

    task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tc,
                         input int stall, input bit noise);
        logic [17:0] e;
        int cyc;
        e = model(ta, tb_, tc);
        @(negedge clk);
        cyc = 0;
        while (!bus.in_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("in_ready_wait", 32'(bus.in_ready), 32'd1);
        bus.in_valid  = 1'b1;
        bus.a         = ta;
        bus.b         = tb_;
        bus.cin       = tc;
        bus.out_ready = (stall == 0);
        @(posedge clk);
        #1;
        // Optionally keep presenting unrelated operands; they must be ignored.
        if (noise) begin
            bus.a   = 16'($urandom);
            bus.b   = 16'($urandom);
            bus.cin = 1'($urandom_range(0, 1));
        end else begin
            bus.in_valid = 1'b0;
        end
        cyc = 0;
        while (!bus.out_valid && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("latency", 32'(cyc), 32'd4);
        chk("sum", 32'(bus.sum), 32'(e[15:0]));
        chk("cout", 32'(bus.cout), 32'(e[16]));
        chk("ovf", 32'(bus.ovf), 32'(e[17]));
        for (int s = 0; s < stall; s++) begin
            @(posedge clk);
            #1;
            chk("stall_valid", 32'(bus.out_valid), 32'd1);
            chk("stall_sum", 32'(bus.sum), 32'(e[15:0]));
            chk("stall_cout", 32'(bus.cout), 32'(e[16]));
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("consumed_valid", 32'(bus.out_valid), 32'd0);
        chk("consumed_ready", 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b0;
        #12;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_sum", 32'(bus.sum), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(16'h1234, 16'h4321, 1'b0, 0, 1'b0);
        do_op(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0);
        do_op(16'h7FFF, 16'h0000, 1'b1, 0, 1'b0);
        do_op(16'h8000, 16'h8000, 1'b0, 0, 1'b0);
        do_op(16'h00FF, 16'h0001, 1'b0, 5, 1'b1);

        // Reset two RUN cycles into an operation.
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.a         = 16'h1234;
        bus.b         = 16'h4321;
        bus.cin       = 1'b1;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_sum", 32'(bus.sum), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(16'h0001, 16'h0001, 1'b0, 0, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            do_op(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
